// File: rtl/coprocessor0_pkg.sv
// Shared CPU constants for coprocessor 0: register numbers, exception codes
// and the packed Status/Cause layouts.
package coprocessor0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_CPU  = 5'h0b;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef struct packed {
    logic [8:0] rsv31_23;
    logic       bev;
    logic [5:0] rsv21_16;
    logic [7:0] im;
    logic [5:0] rsv7_2;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic        bd;
    logic [14:0] rsv30_16;
    logic [7:0]  ip;
    logic        rsv7;
    logic [4:0]  exc_code;
    logic [1:0]  rsv1_0;
  } cause_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, IP7 latches on a
// Count==Compare match until Compare is rewritten.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] write_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic toggle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      compare   <= '0;
      toggle    <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      if (count_wen) begin
        count  <= write_data;
        toggle <= 1'b0;
      end else begin
        toggle <= ~toggle;
        if (toggle) count <= count + 32'd1;
      end
      if (compare_wen) compare <= write_data;
      // A Compare write acknowledges the interrupt even if a match is seen now.
      if (compare_wen)
        timer_int <= 1'b0;
      else if (count == compare)
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/coprocessor0.sv
// Coprocessor 0: Status/Cause/EPC/BadVAddr state, mfc0/mtc0 access and
// exception/eret bookkeeping; timer state lives in cp0_timer.
module coprocessor0
  import coprocessor0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [4:0]  read_addr,
  input  logic [2:0]  read_sel,
  output logic [31:0] read_data,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [2:0]  write_sel,
  input  logic [31:0] write_data,
  input  logic        exp_en,
  input  logic        exl_clean,
  input  logic        exp_bd,
  input  logic        exp_bad_vaddr_wen,
  input  logic [4:0]  exp_code,
  input  logic [31:0] exp_epc,
  input  logic [31:0] exp_bad_vaddr,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc_address,
  output logic        allow_interrupt,
  output logic [7:0]  interrupt_flag
);

  logic [7:0]  im;
  logic        exl, ie, bd, hw5;
  logic [4:0]  exc_code, ip_hw;
  logic [1:0]  ip_sw;
  logic [31:0] epc, bad_vaddr, count, compare;
  logic        timer_int;
  status_t     status_word;
  cause_t      cause_word;

  logic wr_ok, exc, eret;
  assign wr_ok = write_en && !stall && (write_sel == 3'd0);
  assign exc   = exp_en && !stall;
  assign eret  = exl_clean && !stall;

  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .count_wen   (wr_ok && write_addr == CP0_COUNT),
    .compare_wen (wr_ok && write_addr == CP0_COMPARE),
    .write_data  (write_data),
    .count       (count),
    .compare     (compare),
    .timer_int   (timer_int)
  );

  // Exception/eret assignments come last so they override a same-cycle mtc0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      im <= '0; exl <= 1'b0; ie <= 1'b0; bd <= 1'b0; hw5 <= 1'b0;
      exc_code <= '0; ip_hw <= '0; ip_sw <= '0;
      epc <= '0; bad_vaddr <= '0;
    end else begin
      ip_hw <= hw_int[4:0];
      hw5   <= hw_int[5];
      if (wr_ok && write_addr == CP0_STATUS) begin
        im  <= write_data[15:8];
        exl <= write_data[1];
        ie  <= write_data[0];
      end
      if (wr_ok && write_addr == CP0_CAUSE) ip_sw <= write_data[9:8];
      if (wr_ok && write_addr == CP0_EPC) epc <= write_data;
      if (exc) begin
        if (!exl) begin
          epc <= exp_epc;
          bd  <= exp_bd;
        end
        exl      <= 1'b1;
        exc_code <= exp_code;
        if (exp_bad_vaddr_wen) bad_vaddr <= exp_bad_vaddr;
      end else if (eret) begin
        exl <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word     = '0;
    status_word.bev = 1'b1;
    status_word.im  = im;
    status_word.exl = exl;
    status_word.ie  = ie;
    cause_word          = '0;
    cause_word.bd       = bd;
    cause_word.ip       = {timer_int | hw5, ip_hw, ip_sw};
    cause_word.exc_code = exc_code;
  end

  always_comb begin
    read_data = '0;
    if (read_sel == 3'd0) begin
      case (read_addr)
        CP0_BADVADDR: read_data = bad_vaddr;
        CP0_COUNT:    read_data = count;
        CP0_COMPARE:  read_data = compare;
        CP0_STATUS:   read_data = status_word;
        CP0_CAUSE:    read_data = cause_word;
        CP0_EPC:      read_data = epc;
        default:      read_data = '0;
      endcase
    end
  end

  assign epc_address     = epc;
  assign allow_interrupt = ie && !exl;
  assign interrupt_flag  = cause_word.ip & status_word.im;

endmodule
